// File: rtl/quick_spi_pkg.sv
// Shared types and constants for the quick SPI scheduler: FSM encoding,
// operation codes and field widths.
package quick_spi_pkg;

  localparam int unsigned SLAVE_W = 2;
  localparam int unsigned RDATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

// File: rtl/quick_spi_scheduler_if.sv
// Requester-side and SPI-master-side signals of the scheduler, grouped with
// a slave modport for the scheduler and a master modport for its environment.
interface quick_spi_scheduler_if
  import quick_spi_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_operation;
  logic [SLAVE_W*NUM_REQ-1:0]    req_slave;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            error;
  logic [RDATA_W-1:0]            rdata;
  logic                          busy;
  logic                          spi_start;
  logic                          spi_operation;
  logic [SLAVE_W-1:0]            spi_slave;
  logic [DATA_WIDTH-1:0]         spi_outgoing_data;
  logic                          spi_end_of_transaction;
  logic [RDATA_W-1:0]            spi_incoming_data;

  modport slave (
    input  req, req_operation, req_slave, req_wdata,
    input  spi_end_of_transaction, spi_incoming_data,
    output grant, done, error, rdata, busy,
    output spi_start, spi_operation, spi_slave, spi_outgoing_data
  );

  modport master (
    output req, req_operation, req_slave, req_wdata,
    output spi_end_of_transaction, spi_incoming_data,
    input  grant, done, error, rdata, busy,
    input  spi_start, spi_operation, spi_slave, spi_outgoing_data
  );

endinterface

// File: rtl/quick_spi_rr_arbiter.sv
// Round-robin winner search: first asserted request at or after ptr, wrapping.
module quick_spi_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_c,
  output logic [IDX_W-1:0]   index_c
);

  int   cand;
  logic found;

  always_comb begin
    winner_c = '0;
    index_c  = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = (int'(ptr) + i) % int'(NUM_REQ);
      if (!found && req[cand]) begin
        found          = 1'b1;
        winner_c[cand] = 1'b1;
        index_c        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/quick_spi_scheduler.sv
// Shares one SPI master among NUM_REQ requesters: round-robin arbitration,
// command latching, completion capture and transaction timeout.
module quick_spi_scheduler
  import quick_spi_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  quick_spi_scheduler_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    error_q, error_d;
  logic [RDATA_W-1:0]    rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  spi_start_q, spi_start_d;
  logic                  spi_op_q, spi_op_d;
  logic [SLAVE_W-1:0]    spi_slave_q, spi_slave_d;
  logic [DATA_WIDTH-1:0] spi_wdata_q, spi_wdata_d;

  logic [NUM_REQ-1:0]    win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic [SLAVE_W-1:0]    slave_sel [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_sel [NUM_REQ];

  quick_spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req      (bus.req),
    .ptr      (ptr_q),
    .winner_c (win_onehot),
    .index_c  (win_idx)
  );

  // Unpack the per-requester command fields so the winner can index them.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      slave_sel[i] = bus.req_slave[i*SLAVE_W +: SLAVE_W];
      wdata_sel[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      error_q     <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      spi_start_q <= 1'b0;
      spi_op_q    <= 1'b0;
      spi_slave_q <= '0;
      spi_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      spi_start_q <= spi_start_d;
      spi_op_q    <= spi_op_d;
      spi_slave_q <= spi_slave_d;
      spi_wdata_q <= spi_wdata_d;
    end
  end

  // Outputs are computed for the state being entered so they register alongside it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    done_d      = '0;
    error_d     = '0;
    rdata_d     = rdata_q;
    spi_start_d = 1'b0;
    spi_op_d    = spi_op_q;
    spi_slave_d = spi_slave_q;
    spi_wdata_d = spi_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d     = ST_START;
          grant_d     = win_onehot;
          ptr_d       = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
          spi_op_d    = bus.req_operation[win_idx];
          spi_slave_d = slave_sel[win_idx];
          spi_wdata_d = wdata_sel[win_idx];
          spi_start_d = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // A strobe on the terminal count still counts as a completion.
        if (bus.spi_end_of_transaction) begin
          state_d = ST_DONE;
          rdata_d = bus.spi_incoming_data;
          done_d  = grant_q;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ST_ERROR;
          error_d = grant_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE, ST_ERROR: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.grant             = grant_q;
  assign bus.done              = done_q;
  assign bus.error             = error_q;
  assign bus.rdata             = rdata_q;
  assign bus.busy              = busy_q;
  assign bus.spi_start         = spi_start_q;
  assign bus.spi_operation     = spi_op_q;
  assign bus.spi_slave         = spi_slave_q;
  assign bus.spi_outgoing_data = spi_wdata_q;

endmodule

// File: tb/tb_quick_spi_scheduler.sv
// Scenario bench for quick_spi_scheduler: a negedge monitor checks every
// done/error pulse against a queue of expected completions.
module tb_quick_spi_scheduler;
  import quick_spi_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 1024;

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t       sbq [$];
  exp_t       mon_e;
  logic [3:0] mon_oh;
  int         tests = 0;
  int         fails = 0;
  int         starts = 0;
  logic [7:0] model_rdata = 8'h00;

  always #5 clk = ~clk;

  quick_spi_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  quick_spi_scheduler #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .bus           (bus.slave)
  );

  // Completion monitor: pops the scoreboard on every done/error pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      starts = 0;
    end else begin
      if (bus.spi_start) starts++;
      if (bus.done != '0 || bus.error != '0) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: done=%b error=%b with empty queue", bus.done, bus.error);
        end else begin
          mon_e  = sbq.pop_front();
          mon_oh = 4'b0001 << mon_e.idx;
          if (bus.done !== (mon_e.err ? 4'b0000 : mon_oh)) begin
            fails++;
            $display("FAIL sb_done: got %b want %b", bus.done, mon_e.err ? 4'b0000 : mon_oh);
          end
          tests++;
          if (bus.error !== (mon_e.err ? mon_oh : 4'b0000)) begin
            fails++;
            $display("FAIL sb_error: got %b want %b", bus.error, mon_e.err ? mon_oh : 4'b0000);
          end
          tests++;
          if (bus.rdata !== mon_e.data) begin
            fails++;
            $display("FAIL sb_rdata: got %h want %h", bus.rdata, mon_e.data);
          end
          tests++;
          if (starts != 1) begin
            fails++;
            $display("FAIL sb_one_start: got %0d spi_start pulses want 1", starts);
          end
        end
        starts = 0;
      end
    end
  end

  task automatic wait_start(output logic ok, output logic [NR-1:0] g, output logic [DW-1:0] wd);
    ok = 1'b0;
    g  = '0;
    wd = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.spi_start) begin
        ok = 1'b1;
        g  = bus.grant;
        wd = bus.spi_outgoing_data;
        break;
      end
    end
  endtask

  task automatic strobe_after(input int dly, input logic [7:0] d);
    repeat (dly) @(negedge clk);
    bus.spi_end_of_transaction = 1'b1;
    bus.spi_incoming_data      = d;
    @(negedge clk);
    bus.spi_end_of_transaction = 1'b0;
  endtask

  task automatic push_exp(input int idx, input logic err, input logic [7:0] d);
    exp_t e;
    e.idx  = idx;
    e.err  = err;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.spi_end_of_transaction = 1'b0;
    bus.spi_incoming_data = '0;
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_operation[i]         = (i % 2 == 1) ? OP_WRITE : OP_READ;
      bus.req_slave[i*2 +: 2]      = 2'(i);
      bus.req_wdata[i*DW +: DW]    = 16'hA000 + 16'(i);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.grant, bus.done, bus.error} !== 12'h000) begin
      fails++;
      $display("FAIL reset_vectors: grant/done/error got %b want 0", {bus.grant, bus.done, bus.error});
    end
    tests++;
    if ({bus.busy, bus.spi_start, bus.spi_operation} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: busy/start/op got %b want 000", {bus.busy, bus.spi_start, bus.spi_operation});
    end
    tests++;
    if ({bus.rdata, bus.spi_slave, bus.spi_outgoing_data} !== 26'h0) begin
      fails++;
      $display("FAIL reset_data: rdata/slave/wdata got %h want 0", {bus.rdata, bus.spi_slave, bus.spi_outgoing_data});
    end
    rst_n = 1'b1;
  endtask

  task automatic run_sequence(input string name, input logic [NR-1:0] reqs, input int seq [], input logic [7:0] base);
    logic          ok;
    logic [NR-1:0] g;
    logic [DW-1:0] wd;
    @(negedge clk);
    bus.req = reqs;
    for (int k = 0; k < seq.size(); k++) begin
      wait_start(ok, g, wd);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s_start_timeout: no spi_start for grant %0d", name, k);
        break;
      end
      if (g !== (4'b0001 << seq[k])) begin
        fails++;
        $display("FAIL %s_grant%0d: got %b want %b", name, k, g, 4'b0001 << seq[k]);
      end
      tests++;
      if (wd !== 16'hA000 + 16'(seq[k])) begin
        fails++;
        $display("FAIL %s_wdata%0d: got %h want %h", name, k, wd, 16'hA000 + 16'(seq[k]));
      end
      model_rdata = base + 8'(k);
      push_exp(seq[k], 1'b0, model_rdata);
      strobe_after(2, model_rdata);
    end
    bus.req = '0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.grant !== '0) begin
      fails++;
      $display("FAIL %s_idle: busy=%b grant=%b want 0/0000", name, bus.busy, bus.grant);
    end
  endtask

  task automatic test_contention();
    int seq [];
    seq = new[5];
    seq = '{0, 1, 2, 3, 0};
    run_sequence("contention", 4'b1111, seq, 8'h20);
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.req_operation[2] = OP_READ;
    bus.req_slave[5:4]   = 2'd1;
    bus.req_wdata[47:32] = 16'h1A6A;
    bus.req              = 4'b0100;
    @(negedge clk);
    tests++;
    if (bus.spi_start !== 1'b1 || bus.grant !== 4'b0100) begin
      fails++;
      $display("FAIL read_start: start=%b grant=%b want 1/0100", bus.spi_start, bus.grant);
    end
    tests++;
    if ({bus.spi_operation, bus.spi_slave, bus.spi_outgoing_data} !== {1'b0, 2'd1, 16'h1A6A}) begin
      fails++;
      $display("FAIL read_cmd: got %h want %h", {bus.spi_operation, bus.spi_slave, bus.spi_outgoing_data},
               {1'b0, 2'd1, 16'h1A6A});
    end
    model_rdata = 8'h95;
    push_exp(2, 1'b0, 8'h95);
    @(negedge clk);
    tests++;
    if (bus.spi_start !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL read_wait: start=%b busy=%b want 0/1", bus.spi_start, bus.busy);
    end
    bus.spi_end_of_transaction = 1'b1;
    bus.spi_incoming_data      = 8'h95;
    @(negedge clk);
    bus.spi_end_of_transaction = 1'b0;
    bus.req = '0;
    tests++;
    if (bus.done !== 4'b0100 || bus.rdata !== 8'h95) begin
      fails++;
      $display("FAIL read_done: done=%b rdata=%h want 0100/95", bus.done, bus.rdata);
    end
    @(negedge clk);
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL read_release: grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
  endtask

  task automatic test_fairness();
    int seq [];
    seq = new[4];
    seq = '{3, 0, 3, 0};
    run_sequence("fairness", 4'b1001, seq, 8'h40);
  endtask

  task automatic test_timeout();
    logic          ok;
    logic [NR-1:0] g;
    logic [DW-1:0] wd;
    int            cyc;
    logic          seen;
    @(negedge clk);
    bus.req = 4'b0010;
    wait_start(ok, g, wd);
    tests++;
    if (!ok || g !== 4'b0010) begin
      fails++;
      $display("FAIL timeout_grant: ok=%b grant=%b want 1/0010", ok, g);
    end
    push_exp(1, 1'b1, model_rdata);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.error != '0) begin
        seen = 1'b1;
        break;
      end
    end
    bus.req = '0;
    tests++;
    if (!seen || cyc != int'(TO) + 1) begin
      fails++;
      $display("FAIL timeout_latency: seen=%b cycles=%0d want 1/%0d", seen, cyc, TO + 1);
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.grant !== '0 || bus.rdata !== model_rdata) begin
      fails++;
      $display("FAIL timeout_after: busy=%b grant=%b rdata=%h want 0/0000/%h", bus.busy, bus.grant, bus.rdata, model_rdata);
    end
  endtask

  task automatic test_early_drop();
    logic          ok;
    logic [NR-1:0] g;
    logic [DW-1:0] wd;
    @(negedge clk);
    bus.spi_end_of_transaction = 1'b1;
    bus.spi_incoming_data      = 8'hEE;
    @(negedge clk);
    bus.spi_end_of_transaction = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.grant !== '0 || bus.rdata !== model_rdata) begin
      fails++;
      $display("FAIL stray_strobe: busy=%b grant=%b rdata=%h want 0/0000/%h", bus.busy, bus.grant, bus.rdata, model_rdata);
    end
    bus.req = 4'b0001;
    wait_start(ok, g, wd);
    tests++;
    if (!ok || g !== 4'b0001) begin
      fails++;
      $display("FAIL drop_grant: ok=%b grant=%b want 1/0001", ok, g);
    end
    @(negedge clk);
    bus.req = '0;
    model_rdata = 8'h5C;
    push_exp(0, 1'b0, 8'h5C);
    strobe_after(2, 8'h5C);
    tests++;
    if (bus.done !== 4'b0001) begin
      fails++;
      $display("FAIL drop_done: got %b want 0001", bus.done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    logic          ok;
    logic [NR-1:0] g;
    logic [DW-1:0] wd;
    @(negedge clk);
    bus.req = 4'b0100;
    wait_start(ok, g, wd);
    tests++;
    if (!ok || g !== 4'b0100) begin
      fails++;
      $display("FAIL rstwait_grant: ok=%b grant=%b want 1/0100", ok, g);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_rdata = 8'h00;
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.spi_start !== 1'b0 || bus.rdata !== 8'h00) begin
      fails++;
      $display("FAIL rstwait_async: grant=%b busy=%b start=%b rdata=%h want all 0", bus.grant, bus.busy, bus.spi_start, bus.rdata);
    end
    bus.req = 4'b0101;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_start(ok, g, wd);
    tests++;
    if (!ok || g !== 4'b0001) begin
      fails++;
      $display("FAIL rstwait_first: ok=%b grant=%b want 1/0001", ok, g);
    end
    model_rdata = 8'h77;
    push_exp(0, 1'b0, 8'h77);
    strobe_after(1, 8'h77);
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_fairness();
    test_timeout();
    test_early_drop();
    test_reset_in_wait();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d completions never seen", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quick_spi_scheduler.md
QUICK_SPI_SCHEDULER -- requirements
Module: quick_spi_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one SPI master (2..8).
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the outgoing command/data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the maximum clocks spent waiting for end of transaction.
REQ-004 s_axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 s_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 req  in  NUM_REQ  per-requester transaction request, level, held until done or error.
REQ-007 req_operation  in  NUM_REQ  per-requester operation: 0 = read, 1 = write.
REQ-008 req_slave  in  2*NUM_REQ  packed slave index per requester.
REQ-009 req_wdata  in  DATA_WIDTH*NUM_REQ  packed outgoing data per requester.
REQ-010 grant  out  NUM_REQ  one-hot owner of the SPI master, zero when idle.
REQ-011 done  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-012 error  out  NUM_REQ  one-cycle timeout pulse to the owner.
REQ-013 rdata  out  8  captured incoming data, valid in the done cycle, held until next capture.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 spi_start  out  1  one-cycle start_transaction pulse to the SPI master.
REQ-016 spi_operation / spi_slave / spi_outgoing_data  out  1 / 2 / DATA_WIDTH  latched command, stable from START until return to IDLE.
REQ-017 spi_end_of_transaction  in  1  completion strobe from the SPI master.
REQ-018 spi_incoming_data  in  8  received byte from the SPI master.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT, DONE, ERROR.
REQ-020 IDLE: if any req is high, the next edge SHALL select a winner round-robin, set grant, latch its operation/slave/wdata, and enter START.
REQ-021 Round-robin: search begins at pointer ptr, wrapping from NUM_REQ-1 to 0; after a grant ptr SHALL become (winner+1) mod NUM_REQ.
REQ-022 START: spi_start SHALL be high for exactly this one cycle; next state WAIT; timeout counter cleared.
REQ-023 WAIT: spi_end_of_transaction high SHALL capture spi_incoming_data into rdata and enter DONE; strobe outside WAIT SHALL be ignored.
REQ-024 WAIT: counter reaching TIMEOUT_CYCLES-1 without strobe SHALL enter ERROR; strobe and terminal count in the same cycle SHALL resolve as completion.
REQ-025 DONE: done[winner] high one cycle, grant cleared on the exit edge, next state IDLE.
REQ-026 ERROR: error[winner] high one cycle, rdata unchanged, grant cleared, next state IDLE.
REQ-027 Latency: req rising in IDLE -> spi_start 1 clock later; strobe -> done 1 clock later; minimum 1 IDLE cycle between transactions.
REQ-028 Deasserting req after grant SHALL NOT abort; the transaction completes and done/error is still pulsed.
REQ-029 Requests arriving while busy SHALL wait; none is lost while held.

Reset
REQ-030 Assertion of s_axi_aresetn low, at any state, SHALL immediately force IDLE, ptr=0, counter=0, and all outputs (grant, done, error, rdata, busy, spi_*) to 0.
REQ-031 The first arbitration after reset SHALL start from requester 0.

Structure
REQ-032 State encoding, operation constants (READ=0, WRITE=1) and slave-index width SHALL live in shared package quick_spi_pkg.
REQ-033 The winner search SHALL be sub-module quick_spi_rr_arbiter (inputs req, ptr; outputs one-hot winner and index).

Verification
REQ-034 Single read: req[2]=1, op=0, slave=1, wdata=16'h1A6A; strobe with data 8'h95 -> spi_start 1 clk after req, done[2] 1 clk after strobe, rdata=8'h95.
REQ-035 Contention: req=4'b1111 held -> grant order 0,1,2,3,0; each done preceded by exactly one spi_start.
REQ-036 Fairness: req[0] and req[3] constant, ptr after 3 -> next grant 0 then 3, alternating.
REQ-037 Timeout: no strobe for 1024 clocks -> error[owner] pulse, rdata unchanged, busy low next cycle.
REQ-038 Reset in WAIT: aresetn low -> grant, busy, spi_start 0 without clock edge; next grant goes to requester 0.
REQ-039 Early drop/stray strobe: req drops in WAIT and a strobe pulses in IDLE -> done still pulses for owner; idle strobe causes no state change.
